// File: rtl/hex_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : hex_scan_display
// Function : Multiplexed hex 7-segment scanner; new values are loaded only at
//            frame end so a frame never mixes old and new data.
// Revision : 1.0 - initial release
// ============================================================================
module hex_scan_display #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*DIGITS-1:0] value,
    input  logic                lz_blank,
    input  logic                load_valid,
    output logic                load_ready,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int                 c_pc_w     = $clog2(REFRESH_DIV);
    localparam int                 c_idx_w    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_pc_w-1:0]  c_pc_last  = c_pc_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DIGITS - 1);
    localparam logic [6:0]         c_seg_off  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0]  c_an_off   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [c_pc_w-1:0]   pc_q, pc_d;
    logic [c_idx_w-1:0]  idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_val_q, shadow_val_d;
    logic                shadow_lz_q, shadow_lz_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                w_frame_end;
    logic [DIGITS-1:0]   w_zero;
    logic [DIGITS-1:0]   w_lead;
    logic                w_run;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_an_on;

    assign w_frame_end = en && (pc_q == c_pc_last) && (idx_q == c_idx_last);
    assign load_ready  = w_frame_end;
    assign seg         = seg_q;
    assign an          = an_q;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_zero
        assign w_zero[gi]  = (shadow_val_q[4*gi +: 4] == 4'h0);
        assign w_an_on[gi] = (idx_q == c_idx_w'(gi));
    end

    // w_lead[i]: every nibble from digit i up to the top digit is zero
    always_comb begin
        w_run  = 1'b1;
        w_lead = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_run     = w_run & w_zero[i];
            w_lead[i] = w_run;
        end
    end

    assign w_nib   = shadow_val_q[{idx_q, 2'b00} +: 4];
    assign w_blank = shadow_lz_q && (idx_q != '0) && w_lead[idx_q];

    // On-patterns, bit order g..a
    always_comb begin
        w_glyph = 7'b0000000;
        if (!w_blank) begin
            case (w_nib)
                4'h0:    w_glyph = 7'b0111111;
                4'h1:    w_glyph = 7'b0000110;
                4'h2:    w_glyph = 7'b1011011;
                4'h3:    w_glyph = 7'b1001111;
                4'h4:    w_glyph = 7'b1100110;
                4'h5:    w_glyph = 7'b1101101;
                4'h6:    w_glyph = 7'b1111101;
                4'h7:    w_glyph = 7'b0000111;
                4'h8:    w_glyph = 7'b1111111;
                4'h9:    w_glyph = 7'b1101111;
                4'hA:    w_glyph = 7'b1110111;
                4'hB:    w_glyph = 7'b1111100;
                4'hC:    w_glyph = 7'b0111001;
                4'hD:    w_glyph = 7'b1011110;
                4'hE:    w_glyph = 7'b1111001;
                default: w_glyph = 7'b1110001;
            endcase
        end
    end

    always_comb begin
        pc_d         = pc_q;
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_lz_d  = shadow_lz_q;
        if (en) begin
            if (pc_q == c_pc_last) begin
                pc_d  = '0;
                idx_d = (idx_q == c_idx_last) ? '0 : idx_q + 1'b1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
        if (load_valid && w_frame_end) begin
            shadow_val_d = value;
            shadow_lz_d  = lz_blank;
        end
        // Polarity is applied only here, at the output register input
        seg_d = en ? (w_glyph ^ c_seg_off) : c_seg_off;
        an_d  = en ? (w_an_on ^ c_an_off) : c_an_off;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            idx_q        <= '0;
            shadow_val_q <= '0;
            shadow_lz_q  <= 1'b0;
            seg_q        <= c_seg_off;
            an_q         <= c_an_off;
        end else begin
            pc_q         <= pc_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_lz_q  <= shadow_lz_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/hex_scan_display.md
HEX_SCAN_DISPLAY -- requirements
Module: hex_scan_display

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of multiplexed 7-segment digits (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit is driven (legal range >= 2).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = segments and anodes on when 0; 0 = on when 1.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  meaning reset, asynchronous and active-low.
REQ-006 SHALL have port en  input  1  meaning scan enable.
REQ-007 SHALL have port value  input  4*DIGITS  meaning hex nibbles; digit i = value[4i+3:4i], digit 0 rightmost.
REQ-008 SHALL have port lz_blank  input  1  meaning leading-zero blanking enable, sampled with value.
REQ-009 SHALL have port load_valid  input  1  meaning the producer offers value/lz_blank.
REQ-010 SHALL have port load_ready  output  1  meaning the block accepts value this cycle.
REQ-011 SHALL have port seg  output  7  meaning segments; seg[0]=a ... seg[6]=g.
REQ-012 SHALL have port an  output  DIGITS  meaning digit enables, one-hot when active.

Function
REQ-013 SHALL hold a prescale counter pc counting 0..REFRESH_DIV-1, then wrapping to 0; it increments only while en=1.
REQ-014 SHALL hold a digit index idx (0..DIGITS-1); it advances when pc=REFRESH_DIV-1 and en=1, wrapping DIGITS-1 -> 0.
REQ-015 SHALL drive load_ready=1 combinationally only when en=1, pc=REFRESH_DIV-1 and idx=DIGITS-1 (frame end); otherwise 0.
REQ-016 SHALL capture value and lz_blank into a shadow register on the edge where load_valid=1 and load_ready=1; there is no other capture path.
REQ-017 SHALL display captured data starting with digit 0 of the next frame, so no frame mixes old and new data (no tearing).
REQ-018 SHALL not let load_valid be dropped; a producer that holds load_valid waits at most DIGITS*REFRESH_DIV cycles for a transfer.
REQ-019 SHALL decode nibbles 0-F to full hex glyphs (0123456789AbCdEF); polarity-neutral on-patterns g..a: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-020 SHALL, when the shadow lz_blank=1, blank (all segments off) every digit above the most significant non-zero nibble; digit 0 is never blanked (all-zero value shows a single "0").
REQ-021 SHALL register seg and an: they reflect the idx and shadow values from the previous cycle (1-cycle latency).
REQ-022 SHALL drive an one-hot on bit idx when en=1; when en=0, all anodes and segments SHALL be inactive, and pc/idx SHALL hold.
REQ-023 SHALL apply ACTIVE_LOW by inverting on-patterns and anode enables at the output register only.
REQ-024 SHALL make en=0 on a frame-end cycle suppress load_ready, with no capture.

Reset
REQ-025 SHALL, while rst_n=0, force pc=0, idx=0, shadow value=0, shadow lz_blank=0, and seg/an all inactive (all 1s when ACTIVE_LOW=1); load_ready=0.
REQ-026 SHALL, on reset assertion mid-frame, abort the scan immediately and discard any transfer in that cycle; after release, scanning resumes from digit 0, pc=0, on the first enabled edge.

Verification (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1)
REQ-027 SHALL verify reset: rst_n=0 mid-scan -> seg=7'h7F, an=4'hF, load_ready=0 asynchronously; after release with en=1, an=4'hE one cycle later, and seg shows "0".
REQ-028 SHALL verify scan: en=1, value=16'h1234 loaded -> an steps E,D,B,7 every 4 cycles; seg shows 4,3,2,1 (on-patterns 1100110, 1001111, 1011011, 0000110, inverted).
REQ-029 SHALL verify handshake: load_valid=1 with value=16'hBEEF asserted mid-frame -> load_ready pulses once at idx=3, pc=3; the remainder of the current frame shows the old data, the next frame shows F,E,E,b.
REQ-030 SHALL verify blanking: value=16'h0050, lz_blank=1 -> digits 3 and 2 all off (seg=7F), digit 1 "5", digit 0 "0"; with value=16'h0000, only digit 0 shows "0".
REQ-031 SHALL verify enable: en=0 for 10 cycles mid-frame -> an=F, seg=7F, and load_ready=0 even at frame end; on re-enable, the scan resumes at the same idx/pc.
REQ-032 SHALL verify with DIGITS=1 that load_ready pulses every 4 cycles and an=1'b0 whenever en=1.
